instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the PC value loaded on reset.
REQ-002 SHALL have parameter XLEN, default 32, which is the PC and instruction width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port imem_req, output, 1 bit: instruction memory read request.
REQ-006 SHALL have port imem_addr, output, XLEN bits: fetch address.
REQ-007 SHALL have port imem_rdata, input, XLEN bits: returned instruction word.
REQ-008 SHALL have port imem_valid, input, 1 bit: imem_rdata is valid this cycle.
REQ-009 SHALL have port stall, input, 1 bit: downstream is not ready to consume the held instruction.
REQ-010 SHALL have port PCSrc, input, 1 bit: take PCTarget (driven by the control unit).
REQ-011 SHALL have port PCTarget, input, XLEN bits: branch/jump target.
REQ-012 SHALL have port Instr, output, XLEN bits: the instruction register.
REQ-013 SHALL have port instr_valid, output, 1 bit: Instr holds a live instruction.
REQ-014 SHALL have ports PC and PCPlus4, outputs, XLEN bits each: the PC of Instr, and that PC + 4.
REQ-015 SHALL have ports op [6:0], funct3 [2:0], funct7 [0], outputs: Instr[6:0], Instr[14:12], Instr[30].
REQ-016 SHALL have port misaligned, output, 1 bit: sticky fault flag.
REQ-017 SHALL have port retired, output, 32 bits: count of consumed instructions.

Function
REQ-018 SHALL implement FSM states FETCH, HOLD and HALT.
REQ-019 SHALL, in FETCH, drive imem_req=1 and imem_addr=PC; on imem_valid=1 it SHALL latch imem_rdata into Instr, set instr_valid=1 and go to HOLD on the next edge.
REQ-020 SHALL, in FETCH with imem_valid=0, stay in FETCH with PC and Instr unchanged; waits are unbounded.
REQ-021 SHALL, in HOLD, drive imem_req=0 and ignore imem_valid.
REQ-022 SHALL, in HOLD with stall=1, hold all state.
REQ-023 SHALL, in HOLD with stall=0, consume the instruction: PC <= PCSrc ? PCTarget : PC+4, instr_valid <= 0, retired <= retired+1, next state FETCH.
REQ-024 SHALL sample PCSrc and PCTarget only in the consuming HOLD cycle (stall=0); other values are don't-care.
REQ-025 SHALL, when the consuming cycle has PCSrc=1 and PCTarget[1:0]!=0, set misaligned=1, leave PC and retired unchanged, and enter HALT.
REQ-026 SHALL, in HALT, drive imem_req=0 and instr_valid=0; HALT is left only by reset.
REQ-027 SHALL compute PC+4 modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0 without fault.
REQ-028 SHALL let retired wrap from 32'hFFFF_FFFF to 0.
REQ-029 SHALL drive op, funct3 and funct7 combinationally from Instr in all states.
REQ-030 SHALL give a minimum of 2 cycles per instruction (FETCH with immediate imem_valid, then HOLD).

Reset
REQ-031 SHALL, while rst_n=0, immediately force: state=FETCH, PC=RESET_PC, Instr=32'h0000_0013 (NOP), instr_valid=0, misaligned=0, retired=0.
REQ-032 SHALL make imem_req=1 with imem_addr=RESET_PC in the first cycle after rst_n rises.
REQ-033 SHALL, when reset is asserted mid-fetch, discard any imem_valid seen in or after that cycle.

Structure
REQ-034 SHALL place the state encoding (FETCH=2'd0, HOLD=2'd1, HALT=2'd2), the NOP constant and the opcode field positions in a shared package, for reuse by the multicycle control FSM.
REQ-035 SHALL contain exactly one sub-module, pc_next_mux (2:1 XLEN mux plus adder), which produces PCPlus4 and the next PC.

Verification
REQ-036 Bench SHALL cover: reset release, memory returns 32'h00500093 with imem_valid asserted 1 cycle later -> imem_addr=0, Instr=32'h00500093, op=7'h13, instr_valid=1, PC=0.
REQ-037 Bench SHALL cover: stall=1 for 3 cycles in HOLD -> Instr, PC and retired stable, imem_req=0; stall then drops -> PC=4, retired=1.
REQ-038 Bench SHALL cover: consuming cycle with PCSrc=1, PCTarget=32'h0000_0100 -> next imem_addr=32'h100.
REQ-039 Bench SHALL cover: PCSrc=1, PCTarget=32'h0000_0102 -> misaligned=1, HALT, imem_req=0, PC unchanged; rst_n pulse clears all of these.
REQ-040 Bench SHALL cover: PC=32'hFFFF_FFFC consumed without branch -> PC=0, misaligned=0.
REQ-041 Bench SHALL cover: rst_n asserted while waiting in FETCH, with imem_valid pulsed in that same cycle -> instr_valid=0, Instr=NOP, PC=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and the multicycle control FSM:
// state encoding, NOP word and RV32 opcode field positions.
package instr_fetch_unit_pkg;

   typedef enum logic [1:0] {
      StFetch = 2'd0,
      StHold  = 2'd1,
      StHalt  = 2'd2
   } fetch_state_e;

   // addi x0, x0, 0
   localparam logic [31:0] NopInstr = 32'h0000_0013;

   localparam int unsigned OpLsb     = 0;
   localparam int unsigned OpMsb     = 6;
   localparam int unsigned Funct3Lsb = 12;
   localparam int unsigned Funct3Msb = 14;
   localparam int unsigned Funct7Bit = 30;

   // Sequential instruction stride in bytes
   localparam int unsigned PcStep = 4;

   // A jump target is only legal when word aligned
   function automatic logic is_misaligned(input logic [1:0] low_bits);
      return low_bits != 2'b00;
   endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC datapath: sequential PC + 4 (modulo 2^XLEN) and the branch/jump select.
module pc_next_mux
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] pc_target,
   input  logic            pc_src,
   output logic [XLEN-1:0] pc_plus4,
   output logic [XLEN-1:0] pc_next
);

   localparam logic [XLEN-1:0] Step = XLEN'(PcStep);

   always_comb begin
      pc_plus4 = pc + Step;
      pc_next  = pc_src ? pc_target : pc_plus4;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch: request a word, hold it until consumed, then advance the PC.
// A misaligned jump target is a fatal fault that parks the unit until reset.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            imem_valid,
   input  logic            stall,
   input  logic            PCSrc,
   input  logic [XLEN-1:0] PCTarget,
   output logic [XLEN-1:0] Instr,
   output logic            instr_valid,
   output logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] PCPlus4,
   output logic [6:0]      op,
   output logic [2:0]      funct3,
   output logic            funct7,
   output logic            misaligned,
   output logic [31:0]     retired
);

   fetch_state_e    state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] instr_q;
   logic            instr_valid_q;
   logic            misaligned_q;
   logic [31:0]     retired_q;
   logic            imem_req_q;

   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] pc_next;
   logic            target_bad;

   pc_next_mux #(
      .XLEN(XLEN)
   ) u_pc_next_mux (
      .pc       (pc_q),
      .pc_target(PCTarget),
      .pc_src   (PCSrc),
      .pc_plus4 (pc_plus4),
      .pc_next  (pc_next)
   );

   assign target_bad = PCSrc && is_misaligned(PCTarget[1:0]);

   // imem_req is a registered copy of "state is FETCH" so it is already high out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StFetch;
         pc_q          <= RESET_PC;
         instr_q       <= XLEN'(NopInstr);
         instr_valid_q <= 1'b0;
         misaligned_q  <= 1'b0;
         retired_q     <= '0;
         imem_req_q    <= 1'b1;
      end else begin
         case (state_q)
            StFetch: begin
               if (imem_valid) begin
                  instr_q       <= imem_rdata;
                  instr_valid_q <= 1'b1;
                  imem_req_q    <= 1'b0;
                  state_q       <= StHold;
               end
            end
            StHold: begin
               if (!stall) begin
                  instr_valid_q <= 1'b0;
                  if (target_bad) begin
                     misaligned_q <= 1'b1;
                     imem_req_q   <= 1'b0;
                     state_q      <= StHalt;
                  end else begin
                     pc_q       <= pc_next;
                     retired_q  <= retired_q + 32'd1;
                     imem_req_q <= 1'b1;
                     state_q    <= StFetch;
                  end
               end
            end
            StHalt: begin
               instr_valid_q <= 1'b0;
               imem_req_q    <= 1'b0;
            end
            default: begin
               state_q       <= StHalt;
               instr_valid_q <= 1'b0;
               imem_req_q    <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      imem_req    = imem_req_q;
      imem_addr   = pc_q;
      Instr       = instr_q;
      instr_valid = instr_valid_q;
      PC          = pc_q;
      PCPlus4     = pc_plus4;
      misaligned  = misaligned_q;
      retired     = retired_q;
      op          = instr_q[OpMsb:OpLsb];
      funct3      = instr_q[Funct3Msb:Funct3Lsb];
      funct7      = instr_q[Funct7Bit];
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a transaction-level model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_instr_fetch_unit;

   localparam logic [31:0] Nop = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        imem_valid = 1'b0;
   logic        stall = 1'b0;
   logic        PCSrc = 1'b0;
   logic [31:0] PCTarget = 32'h0;
   logic [31:0] Instr;
   logic        instr_valid;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7;
   logic        misaligned;
   logic [31:0] retired;

   int vectors = 0;
   int miscompares = 0;

   instr_fetch_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_valid (imem_valid),
      .stall      (stall),
      .PCSrc      (PCSrc),
      .PCTarget   (PCTarget),
      .Instr      (Instr),
      .instr_valid(instr_valid),
      .PC         (PC),
      .PCPlus4    (PCPlus4),
      .op         (op),
      .funct3     (funct3),
      .funct7     (funct7),
      .misaligned (misaligned),
      .retired    (retired)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Model: the unit either waits for a word, holds one, or is halted for good
   logic [31:0] m_pc, m_instr, m_ret;
   logic        m_have, m_halt, m_mis;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc <= 32'h0; m_instr <= Nop; m_ret <= 32'h0;
         m_have <= 1'b0; m_halt <= 1'b0; m_mis <= 1'b0;
      end else if (m_halt) begin
         m_have <= 1'b0;
      end else if (!m_have) begin
         if (imem_valid) begin
            m_instr <= imem_rdata;
            m_have  <= 1'b1;
         end
      end else if (!stall) begin
         m_have <= 1'b0;
         if (PCSrc && (PCTarget % 4 != 0)) begin
            m_mis  <= 1'b1;
            m_halt <= 1'b1;
         end else begin
            m_pc  <= PCSrc ? PCTarget : m_pc + 32'd4;
            m_ret <= m_ret + 32'd1;
         end
      end
   end

   always @(negedge clk) begin
      check("imem_req", {31'b0, imem_req}, {31'b0, !m_have && !m_halt});
      check("imem_addr", imem_addr, m_pc);
      check("Instr", Instr, m_instr);
      check("instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
      check("PC", PC, m_pc);
      check("PCPlus4", PCPlus4, m_pc + 32'd4);
      check("op", {25'b0, op}, {25'b0, m_instr[6:0]});
      check("funct3", {29'b0, funct3}, {29'b0, m_instr[14:12]});
      check("funct7", {31'b0, funct7}, {31'b0, m_instr[30]});
      check("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
      check("retired", retired, m_ret);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Stall is left high while fetching to show it is ignored outside HOLD
   task automatic fetch_word(input logic [31:0] w, input int wait_cycles);
      imem_valid = 1'b0;
      stall = 1'b1;
      repeat (wait_cycles) step();
      imem_valid = 1'b1;
      imem_rdata = w;
      step();
      imem_valid = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
   endtask

   // Non-consuming cycles carry a bogus misaligned branch and a stray imem_valid
   task automatic consume(input logic src, input logic [31:0] tgt, input int stall_cycles);
      stall = 1'b1;
      PCSrc = 1'b1;
      PCTarget = 32'h0000_0003;
      imem_valid = 1'b1;
      imem_rdata = 32'hBAD0_0BAD;
      repeat (stall_cycles) step();
      imem_valid = 1'b0;
      stall = 1'b0;
      PCSrc = src;
      PCTarget = tgt;
      step();
      stall = 1'b1;
      PCSrc = 1'b1;
      PCTarget = 32'h0000_0003;
   endtask

   initial begin
      // Reset and release
      repeat (2) step();
      check("rst_instr", Instr, Nop);
      check("rst_valid", {31'b0, instr_valid}, 32'h0);
      rst_n = 1'b1;
      #1;
      check("first_req", {31'b0, imem_req}, 32'h1);
      check("first_addr", imem_addr, 32'h0);

      // Fetch with one wait cycle, then stall three cycles in HOLD
      fetch_word(32'h0050_0093, 1);
      check("t1_instr", Instr, 32'h0050_0093);
      check("t1_op", {25'b0, op}, 32'h13);
      check("t1_valid", {31'b0, instr_valid}, 32'h1);
      check("t1_pc", PC, 32'h0);
      stall = 1'b1;
      imem_valid = 1'b1;
      repeat (3) step();
      check("t1_stall_instr", Instr, 32'h0050_0093);
      check("t1_stall_pc", PC, 32'h0);
      check("t1_stall_ret", retired, 32'h0);
      check("t1_stall_req", {31'b0, imem_req}, 32'h0);
      consume(1'b0, 32'h0, 0);
      check("t1_pc4", PC, 32'h4);
      check("t1_ret", retired, 32'h1);

      // Back-to-back fetch, taken branch
      fetch_word(32'h00A0_0113, 0);
      consume(1'b1, 32'h0000_0100, 0);
      check("t2_addr", imem_addr, 32'h100);
      check("t2_req", {31'b0, imem_req}, 32'h1);

      // R-type decode fields, then jump to the top of the address space
      fetch_word(32'h4020_8033, 2);
      check("t3_op", {25'b0, op}, 32'h33);
      check("t3_f3", {29'b0, funct3}, 32'h0);
      check("t3_f7", {31'b0, funct7}, 32'h1);
      consume(1'b1, 32'hFFFF_FFFC, 1);
      check("t3_pc", PC, 32'hFFFF_FFFC);

      // Sequential advance wraps to zero
      fetch_word(32'h0000_1013, 0);
      check("t4_pc4", PCPlus4, 32'h0);
      check("t4_f3", {29'b0, funct3}, 32'h1);
      consume(1'b0, 32'h0, 0);
      check("t4_pc", PC, 32'h0);
      check("t4_mis", {31'b0, misaligned}, 32'h0);
      check("t4_ret", retired, 32'h4);

      // Misaligned target halts
      fetch_word(Nop, 0);
      consume(1'b1, 32'h0000_0102, 0);
      check("t5_mis", {31'b0, misaligned}, 32'h1);
      check("t5_req", {31'b0, imem_req}, 32'h0);
      check("t5_pc", PC, 32'h0);
      check("t5_ret", retired, 32'h4);
      stall = 1'b0;
      PCSrc = 1'b0;
      imem_valid = 1'b1;
      repeat (3) step();
      check("t5_halt_req", {31'b0, imem_req}, 32'h0);
      check("t5_halt_valid", {31'b0, instr_valid}, 32'h0);
      imem_valid = 1'b0;

      // Reset pulse leaves HALT
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      check("t6_mis", {31'b0, misaligned}, 32'h0);
      check("t6_req", {31'b0, imem_req}, 32'h1);
      check("t6_ret", retired, 32'h0);

      // Reset while waiting in FETCH, with imem_valid in the same cycle
      fetch_word(32'h0050_0093, 0);
      consume(1'b0, 32'h0, 0);
      check("t7_pc_before", PC, 32'h4);
      step();
      rst_n = 1'b0;
      imem_valid = 1'b1;
      imem_rdata = 32'h1234_5678;
      step();
      rst_n = 1'b1;
      imem_valid = 1'b0;
      step();
      check("t7_valid", {31'b0, instr_valid}, 32'h0);
      check("t7_instr", Instr, Nop);
      check("t7_pc", PC, 32'h0);

      step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
